// File: rtl/pattern_detector_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package pattern_detector_pkg;

    localparam int          DEF_PAT_LEN_MAX = 8;
    localparam int          DEF_LEN_W       = $clog2(DEF_PAT_LEN_MAX + 1);
    localparam int          DEF_CNT_W       = 16;
    localparam logic [31:0] DEF_PAT         = 32'h0000_000D;
    localparam int          DEF_LEN         = 6;
    localparam logic        DEF_OVL         = 1'b0;

    // Ones in bit positions [len-1:0]; len of 0 yields an empty mask.
    function automatic logic [31:0] len_mask(input int unsigned len);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coincident with an increment yields 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pattern_detector_prog.sv
// Programmable serial pattern detector with overlap mode and saturating match counter.
// Optional PATTERN_DETECTOR_MATCH_IDX_EN adds match_idx_o (index of the completing bit).
module pattern_detector_prog
    import pattern_detector_pkg::*;
#(
    parameter int                    PAT_LEN_MAX = DEF_PAT_LEN_MAX,
    parameter int                    CNT_W       = DEF_CNT_W,
    parameter logic [PAT_LEN_MAX-1:0] DEFAULT_PAT = PAT_LEN_MAX'(DEF_PAT),
    parameter int                    DEFAULT_LEN = DEF_LEN,
    parameter logic                  DEFAULT_OVL = DEF_OVL
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               valid_i,
    input  logic                               data_i,
    input  logic                               cfg_load_i,
    input  logic [PAT_LEN_MAX-1:0]             cfg_pat_i,
    input  logic [$clog2(PAT_LEN_MAX+1)-1:0]   cfg_len_i,
    input  logic                               cfg_ovl_i,
    input  logic                               cnt_clr_i,
`ifdef PATTERN_DETECTOR_MATCH_IDX_EN
    output logic [31:0]                        match_idx_o,
`endif
    output logic                               pattern_detect_o,
    output logic [CNT_W-1:0]                   match_count_o
);

    localparam int LEN_W = $clog2(PAT_LEN_MAX + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_LEN_MAX);
    localparam logic [LEN_W-1:0] LEN_RST =
        (DEFAULT_LEN > PAT_LEN_MAX) ? LEN_MAX : LEN_W'(DEFAULT_LEN);

    logic [PAT_LEN_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]       fill_q, fill_d;
    logic [PAT_LEN_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   ovl_q, ovl_d;
    logic                   det_q, det_d;

    logic                   accept;
    logic [PAT_LEN_MAX:0]   hist_ext;
    logic [LEN_W-1:0]       fill_inc;
    logic [31:0]            mask_full;
    logic [32:0]            diff;
    logic                   match;

    assign accept    = valid_i & ~cfg_load_i;
    assign hist_ext  = {hist_q, data_i};
    assign fill_inc  = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    assign mask_full = len_mask(32'(len_q));
    // The bit shifted out of hist sits above any legal length, so the mask drops it.
    assign diff      = 33'(hist_ext ^ {1'b0, pat_q}) & {1'b0, mask_full};
    assign match     = accept && (len_q != '0) && (fill_inc >= len_q) && (diff == '0);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        det_d  = match;
        if (cfg_load_i) begin
            pat_d  = cfg_pat_i;
            len_d  = (cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;
            ovl_d  = cfg_ovl_i;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_ext[PAT_LEN_MAX-1:0];
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEFAULT_PAT;
            len_q  <= LEN_RST;
            ovl_q  <= DEFAULT_OVL;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            det_q  <= det_d;
        end
    end

    assign pattern_detect_o = det_q;

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (match),
        .clr_i   (cnt_clr_i),
        .count_o (match_count_o)
    );

`ifdef PATTERN_DETECTOR_MATCH_IDX_EN
    logic [31:0] idx_q, idx_d;
    logic [31:0] midx_q, midx_d;

    always_comb begin
        idx_d  = accept ? idx_q + 32'd1 : idx_q;
        midx_d = match ? idx_q : midx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            midx_q <= '0;
        end else begin
            idx_q  <= idx_d;
            midx_q <= midx_d;
        end
    end

    assign match_idx_o = midx_q;
`endif

endmodule

// File: tb/tb_pattern_detector_prog.sv
// Directed bench for pattern_detector_prog: main instance plus a 2-bit-counter instance.
module tb_pattern_detector_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       data = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pat = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_ovl = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       det, det2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
`ifdef PATTERN_DETECTOR_MATCH_IDX_EN
    logic [31:0] midx, midx2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pattern_detector_prog #(.PAT_LEN_MAX(8), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
        .cfg_load_i(cfg_load), .cfg_pat_i(cfg_pat), .cfg_len_i(cfg_len),
        .cfg_ovl_i(cfg_ovl), .cnt_clr_i(cnt_clr),
`ifdef PATTERN_DETECTOR_MATCH_IDX_EN
        .match_idx_o(midx),
`endif
        .pattern_detect_o(det), .match_count_o(cnt)
    );

    pattern_detector_prog #(.PAT_LEN_MAX(8), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
        .cfg_load_i(cfg_load), .cfg_pat_i(cfg_pat), .cfg_len_i(cfg_len),
        .cfg_ovl_i(cfg_ovl), .cnt_clr_i(cnt_clr),
`ifdef PATTERN_DETECTOR_MATCH_IDX_EN
        .match_idx_o(midx2),
`endif
        .pattern_detect_o(det2), .match_count_o(cnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic clr);
        valid   = v;
        data    = d;
        cnt_clr = clr;
        @(posedge clk);
        #1;
        valid   = 1'b0;
        data    = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic v, input logic d);
        cfg_pat  = pat;
        cfg_len  = len;
        cfg_ovl  = ovl;
        cfg_load = 1'b1;
        step(v, d, 1'b0);
        cfg_load = 1'b0;
        check_val("load_det", 32'(det), 32'd0);
    endtask

    // Sends n bits MSB first; hits[i] is the expected detect after bit i.
    task automatic send(input string tag, input logic [31:0] bits, input int n,
                        input logic [31:0] hits);
        logic [31:0] b, h;
        b = bits;
        h = hits;
        for (int i = 0; i < n; i++) begin
            step(1'b1, b[n-1-i], 1'b0);
            check_val($sformatf("%s_b%0d", tag, i), 32'(det), 32'(h[i]));
        end
    endtask

    initial begin
        int pulses;
        logic rb;

        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_val("rst_det", 32'(det), 32'd0);
        check_val("rst_cnt", 32'(cnt), 32'd0);
        check_val("rst_cnt2", 32'(cnt2), 32'd0);

        send("dflt", 32'b001101, 6, 32'b100000);
        check_val("dflt_cnt", 32'(cnt), 32'd1);
`ifdef PATTERN_DETECTOR_MATCH_IDX_EN
        check_val("dflt_idx", midx, 32'd5);
`endif

        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        send("ovl1", 32'b10101, 5, 32'b10100);
        check_val("ovl1_cnt", 32'(cnt), 32'd3);
        load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        send("ovl0", 32'b10101, 5, 32'b00100);
        check_val("ovl0_cnt", 32'(cnt), 32'd4);

        load(8'b0000_1101, 4'd6, 1'b0, 1'b0, 1'b0);
        send("gap_a", 32'b0011, 4, 32'b0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check_val("gap_idle", 32'(det), 32'd0);
        end
        send("gap_b", 32'b01, 2, 32'b10);
        check_val("gap_cnt", 32'(cnt), 32'd5);

        send("abort_a", 32'b0011, 4, 32'b0000);
        load(8'b0000_1101, 4'd6, 1'b0, 1'b1, 1'b0);
        send("abort_b", 32'b01, 2, 32'b00);
        check_val("abort_cnt", 32'(cnt), 32'd5);

        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check_val($sformatf("sat_%0d", i), 32'(cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        check_val("sat_wide", 32'(cnt), 32'd5);
        step(1'b1, 1'b1, 1'b1);
        check_val("clr_match2", 32'(cnt2), 32'd1);
        check_val("clr_match", 32'(cnt), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        check_val("clr_only2", 32'(cnt2), 32'd0);
        check_val("clr_only", 32'(cnt), 32'd0);

        load(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            rb = 1'($urandom_range(0, 1));
            step(1'b1, rb, 1'b0);
            if (det) pulses++;
        end
        check_val("len0_pulses", 32'(pulses), 32'd0);
        check_val("len0_cnt", 32'(cnt), 32'd0);

        load(8'b1011_0011, 4'd9, 1'b0, 1'b0, 1'b0);
        send("len9", 32'b1011_0011, 8, 32'b1000_0000);
        check_val("len9_cnt", 32'(cnt), 32'd1);
        load(8'b1111_0101, 4'd3, 1'b0, 1'b0, 1'b0);
        send("hibits", 32'b101, 3, 32'b100);
        check_val("hibits_cnt", 32'(cnt), 32'd2);

        load(8'b0000_1101, 4'd6, 1'b0, 1'b0, 1'b0);
        send("mid_a", 32'b00110, 5, 32'b00000);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check_val("mid_rst_det", 32'(det), 32'd0);
        check_val("mid_rst_cnt", 32'(cnt), 32'd0);
        send("mid_b", 32'b1, 1, 32'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
